hazard_flush_ctrl: RTL and testbench
====================================

Name: hazard_flush_ctrl

Overview:
- Pipeline scheduler for the decode/register-select stage. Tracks in-flight destination registers in a scoreboard and detects read-after-write hazards on the decode sources (a0/a1).
- On a hazard it inserts bubbles: drives decode squash and holds fetch. On a taken jump it flushes younger instructions for a fixed number of cycles.
- Drives the global stall from the external memory-busy input and keeps bubble/flush performance counters.

Parameters:
- DEPTH, 3, scoreboard entries; equals decode-to-register-write latency (execute, memory, writeback).
- WB_BYPASS, 1, 1 = register file is write-through, so the oldest (writeback) entry is excluded from hazard compare.
- SQUASH_CYCLES, 2, cycles squashed after a taken jump (decode instruction plus the in-flight fetch); legal range 1..15.

Ports:
- clk  input  1  pipeline clock
- rst  input  1  asynchronous, active-low reset
- a0  input  5  decode source register 0
- a1  input  5  decode source register 1
- a2_hazard  input  5  decode destination register, already zeroed when squashed or when there is no write
- jmp_taken  input  1  execute stage resolved a taken jump/branch this cycle
- mem_busy  input  1  memory not ready; pipeline must freeze
- stall  output  1  global freeze to all pipeline latches
- squash  output  1  decode squash: bubble into execute
- fetch_hold  output  1  hold PC/instruction register so the decode instruction is re-presented
- flushing  output  1  flush window active (registered state)
- bubble_count  output  32  cycles a hazard bubble was inserted
- flush_count  output  32  jumps that started a flush

Behaviour:
- Reset (rst=0, asynchronous):
  - All scoreboard entries = 0, flush counter = 0, bubble_count = 0, flush_count = 0.
  - Outputs then: stall = mem_busy, squash = 0, fetch_hold = 0, flushing = 0 (inputs a0/a1 compare against empty scoreboard).
- stall = mem_busy, combinational. While stall = 1, no state changes: scoreboard, flush counter and perf counters all hold. jmp_taken is ignored while stall = 1, because execute is frozen and re-presents it.
- Scoreboard: sb[0..DEPTH-1] of 5-bit registers. On each clk edge with stall = 0: sb[0] <= a2_hazard, sb[i] <= sb[i-1]. Register x0 is never a hazard.
- hazard (combinational) = (a0 != 0 and a0 equals any active sb entry) or (a1 != 0 and a1 equals any active sb entry).
  - Active entries are sb[0..DEPTH-1], or sb[0..DEPTH-2] when WB_BYPASS = 1.
  - hazard is suppressed when flushing = 1 or jmp_taken = 1, because the decode instruction is dead.
- Flush FSM, two states:
  - RUN (cnt = 0): if jmp_taken and not stall, go to FLUSH with cnt <= SQUASH_CYCLES-1. If SQUASH_CYCLES = 1, stay in RUN.
  - FLUSH (cnt > 0): each unstalled cycle cnt <= cnt-1; return to RUN when cnt reaches 0.
  - jmp_taken while in FLUSH reloads cnt <= SQUASH_CYCLES-1 and counts a new flush.
  - flushing = (cnt != 0).
- squash = hazard or jmp_taken or flushing.
- fetch_hold = hazard only. Never asserted during a jump or flush, so fetch can redirect.
- Bubble latency: hazard is seen in cycle t and squash/fetch_hold are asserted in the same cycle. The bubble (a2_hazard = 0) enters sb[0] at edge t+1. The same decode instruction is re-evaluated at t+1 and stays held until its producer leaves the active window.
- Max bubbles per hazard: DEPTH-WB_BYPASS (2 by default) when the producer is immediately ahead.
- Counters, on unstalled edges only, wrapping at 2^32:
  - bubble_count +1 on each edge with hazard = 1.
  - flush_count +1 on each edge with jmp_taken = 1.
- Simultaneous events:
  - jmp_taken and a hazard in the same cycle: jump wins. No fetch_hold, no bubble count.
  - mem_busy together with hazard: squash/fetch_hold stay asserted combinationally, but nothing advances.
- Reset asserted mid-flush or mid-bubble: all state clears immediately. No residual squash after reset release unless inputs create one.

Test Plan:
- Back-to-back dependency: decode writes x5 (a2_hazard=5), next instruction has a0=5. Required: squash=1 and fetch_hold=1 for exactly 2 cycles, then 0 on the 3rd cycle; bubble_count=2.
- x0 and no-write: a2_hazard=0 ahead of an instruction with a0=0, a1=0. Required: no squash and bubble_count stays 0. Repeat with a1=7 and sb all different → no squash.
- Taken jump: jmp_taken pulse in cycle t with a0 matching sb[0]. Required: squash=1 in cycles t and t+1; fetch_hold=0 throughout; flushing=1 in t+1 only; flush_count=1; bubble_count unchanged.
- Jump during flush: second jmp_taken in cycle t+1. Required: squash continues through t+2; flush_count=2.
- Memory freeze: hazard active, mem_busy=1 for 4 cycles. Required: stall=1 for those cycles; sb contents and bubble_count frozen. After release, the remaining bubble count completes as in scenario 1 (total 2).
- Async reset: assert rst=0 mid-flush, between clock edges. Required: flushing, squash and counters go to 0 immediately without a clock edge; after rst=1, first instruction with a0=5 produces no hazard.

Source files
------------

// File: rtl/hazard_flush_ctrl.sv
// Decode-stage hazard/flush scheduler: tracks in-flight destination registers,
// inserts bubbles on read-after-write hazards, squashes younger instructions
// after a taken jump, and keeps bubble/flush performance counters.
module hazard_flush_ctrl #(
    parameter int unsigned DEPTH         = 3,
    parameter int unsigned WB_BYPASS     = 1,
    parameter int unsigned SQUASH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  a0,
    input  logic [4:0]  a1,
    input  logic [4:0]  a2_hazard,
    input  logic        jmp_taken,
    input  logic        mem_busy,
    output logic        stall,
    output logic        squash,
    output logic        fetch_hold,
    output logic        flushing,
    output logic [31:0] bubble_count,
    output logic [31:0] flush_count
);

    // Entries younger than this index can still be hazards; the writeback
    // entry drops out when the register file writes through.
    localparam int unsigned ACTIVE   = DEPTH - WB_BYPASS;
    localparam logic [3:0]  CNT_LOAD = 4'(SQUASH_CYCLES - 1);

    typedef enum logic {StRun, StFlush} state_e;

    state_e      r_state;
    state_e      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [4:0]  r_sb [DEPTH];
    logic [DEPTH-1:0] w_hit;
    logic        w_match;
    logic        w_hazard;
    logic        w_advance;
    logic [31:0] r_bubble_count;
    logic [31:0] r_flush_count;

    assign w_advance = ~mem_busy;

    // Scoreboard head: newest decode destination enters when not stalled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sb[0] <= '0;
        end else if (w_advance) begin
            r_sb[0] <= a2_hazard;
        end
    end

    genvar g;
    generate
        for (g = 1; g < DEPTH; g++) begin : g_sb_shift
            // Older entries age one stage per unstalled cycle
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_sb[g] <= '0;
                end else if (w_advance) begin
                    r_sb[g] <= r_sb[g-1];
                end
            end
        end

        for (g = 0; g < DEPTH; g++) begin : g_sb_hit
            if (g < ACTIVE) begin : g_active
                assign w_hit[g] = ((a0 != 5'd0) && (a0 == r_sb[g])) ||
                                  ((a1 != 5'd0) && (a1 == r_sb[g]));
            end else begin : g_inactive
                assign w_hit[g] = 1'b0;
            end
        end
    endgenerate

    assign w_match  = |w_hit;
    // A dead decode instruction (jump or flush window) never raises a hazard
    assign w_hazard = w_match & ~flushing & ~jmp_taken;

    // Flush FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StRun;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Flush FSM next state: jumps (re)load the window, otherwise count down
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (w_advance) begin
            if (jmp_taken) begin
                w_cnt_nxt   = CNT_LOAD;
                w_state_nxt = (CNT_LOAD != 4'd0) ? StFlush : StRun;
            end else if (r_state == StFlush) begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt = StRun;
                end
            end
        end
    end

    // Performance counters advance only on unstalled edges
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bubble_count <= '0;
            r_flush_count  <= '0;
        end else if (w_advance) begin
            if (w_hazard) begin
                r_bubble_count <= r_bubble_count + 32'd1;
            end
            if (jmp_taken) begin
                r_flush_count <= r_flush_count + 32'd1;
            end
        end
    end

    // Pipeline control outputs
    always_comb begin
        stall        = mem_busy;
        flushing     = (r_cnt != 4'd0);
        squash       = w_hazard | jmp_taken | flushing;
        // Fetch must stay free to redirect during a jump or flush
        fetch_hold   = w_hazard;
        bubble_count = r_bubble_count;
        flush_count  = r_flush_count;
    end

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Self-checking bench for hazard_flush_ctrl: directed scenarios followed by a
// randomized run, all compared against a queue-based reference model.
module tb_hazard_flush_ctrl;

    localparam int DEPTH = 3;
    localparam int WB    = 1;
    localparam int SC    = 2;

    logic        clk;
    logic        rst;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [4:0]  a2_hazard;
    logic        jmp_taken;
    logic        mem_busy;
    logic        stall;
    logic        squash;
    logic        fetch_hold;
    logic        flushing;
    logic [31:0] bubble_count;
    logic [31:0] flush_count;

    int n_checks;
    int n_fail;

    // Reference model state
    int          m_sb[$];
    int          m_fl;
    logic [31:0] m_bub;
    logic [31:0] m_fcnt;
    logic [31:0] save_bub;
    logic [31:0] save_fcnt;

    hazard_flush_ctrl #(
        .DEPTH        (DEPTH),
        .WB_BYPASS    (WB),
        .SQUASH_CYCLES(SC)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .a0          (a0),
        .a1          (a1),
        .a2_hazard   (a2_hazard),
        .jmp_taken   (jmp_taken),
        .mem_busy    (mem_busy),
        .stall       (stall),
        .squash      (squash),
        .fetch_hold  (fetch_hold),
        .flushing    (flushing),
        .bubble_count(bubble_count),
        .flush_count (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        m_sb.delete();
        for (int i = 0; i < DEPTH; i++) m_sb.push_back(0);
        m_fl   = 0;
        m_bub  = '0;
        m_fcnt = '0;
    endfunction

    // Hazard per the rules: sources vs. in-flight writers, dead instr excluded
    function automatic bit m_hazard(input int s0, input int s1, input bit jmp);
        if (jmp || m_fl > 0) return 1'b0;
        for (int i = 0; i < DEPTH - WB; i++) begin
            if ((s0 != 0 && m_sb[i] == s0) || (s1 != 0 && m_sb[i] == s1)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit m_squash(input int s0, input int s1, input bit jmp);
        return m_hazard(s0, s1, jmp) || jmp || (m_fl > 0);
    endfunction

    task automatic drive(input int s0, input int s1, input int d, input bit jmp, input bit busy);
        a0        = 5'(s0);
        a1        = 5'(s1);
        a2_hazard = 5'(d);
        jmp_taken = jmp;
        mem_busy  = busy;
        #1;
    endtask

    task automatic check_model();
        bit hz;
        hz = m_hazard(int'(a0), int'(a1), jmp_taken);
        chk("m_stall", {31'd0, stall}, {31'd0, mem_busy});
        chk("m_squash", {31'd0, squash}, {31'd0, m_squash(int'(a0), int'(a1), jmp_taken)});
        chk("m_fetch_hold", {31'd0, fetch_hold}, {31'd0, hz});
        chk("m_flushing", {31'd0, flushing}, {31'd0, (m_fl > 0)});
        chk("m_bubble_count", bubble_count, m_bub);
        chk("m_flush_count", flush_count, m_fcnt);
    endtask

    // Advance one clock; model follows the DUT on the same edge
    task automatic tick();
        bit hz;
        hz = m_hazard(int'(a0), int'(a1), jmp_taken);
        @(posedge clk);
        if (!mem_busy) begin
            if (hz) m_bub++;
            if (jmp_taken) m_fcnt++;
            m_sb.push_front(int'(a2_hazard));
            void'(m_sb.pop_back());
            if (jmp_taken) m_fl = SC - 1;
            else if (m_fl > 0) m_fl--;
        end
        @(negedge clk);
    endtask

    task automatic step(input int s0, input int s1, input int d, input bit jmp, input bit busy);
        drive(s0, s1, d, jmp, busy);
        check_model();
        tick();
    endtask

    initial begin
        int s0, s1, d;
        bit jmp, busy;
        n_checks = 0;
        n_fail   = 0;
        m_reset();

        // Reset state
        rst = 1'b0;
        drive(5, 0, 0, 1'b0, 1'b1);
        chk("rst_stall_busy", {31'd0, stall}, 32'd1);
        drive(5, 0, 0, 1'b0, 1'b0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_squash", {31'd0, squash}, 32'd0);
        chk("rst_fetch_hold", {31'd0, fetch_hold}, 32'd0);
        chk("rst_flushing", {31'd0, flushing}, 32'd0);
        chk("rst_bubble", bubble_count, 32'd0);
        chk("rst_flushcnt", flush_count, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Back-to-back dependency on x5: two bubbles
        step(0, 0, 5, 1'b0, 1'b0);
        drive(5, 0, 0, 1'b0, 1'b0);
        check_model();
        chk("b2b_sq_t0", {31'd0, squash}, 32'd1);
        chk("b2b_fh_t0", {31'd0, fetch_hold}, 32'd1);
        tick();
        drive(5, 0, 0, 1'b0, 1'b0);
        chk("b2b_sq_t1", {31'd0, squash}, 32'd1);
        chk("b2b_fh_t1", {31'd0, fetch_hold}, 32'd1);
        tick();
        drive(5, 0, 6, 1'b0, 1'b0);
        chk("b2b_sq_t2", {31'd0, squash}, 32'd0);
        chk("b2b_fh_t2", {31'd0, fetch_hold}, 32'd0);
        tick();
        chk("b2b_bubbles", bubble_count, 32'd2);

        // x0 sources and non-matching sources never hazard
        step(0, 0, 0, 1'b0, 1'b0);
        drive(0, 0, 3, 1'b0, 1'b0);
        chk("x0_squash", {31'd0, squash}, 32'd0);
        tick();
        step(0, 0, 4, 1'b0, 1'b0);
        drive(0, 7, 9, 1'b0, 1'b0);
        chk("nomatch_squash", {31'd0, squash}, 32'd0);
        tick();
        chk("x0_bubbles", bubble_count, 32'd2);

        // Taken jump with a matching source: jump wins
        save_bub  = bubble_count;
        save_fcnt = flush_count;
        step(0, 0, 8, 1'b0, 1'b0);
        drive(8, 0, 0, 1'b1, 1'b0);
        check_model();
        chk("jmp_sq_t", {31'd0, squash}, 32'd1);
        chk("jmp_fh_t", {31'd0, fetch_hold}, 32'd0);
        chk("jmp_fl_t", {31'd0, flushing}, 32'd0);
        tick();
        drive(8, 0, 0, 1'b0, 1'b0);
        chk("jmp_sq_t1", {31'd0, squash}, 32'd1);
        chk("jmp_fh_t1", {31'd0, fetch_hold}, 32'd0);
        chk("jmp_fl_t1", {31'd0, flushing}, 32'd1);
        tick();
        drive(0, 0, 0, 1'b0, 1'b0);
        chk("jmp_sq_t2", {31'd0, squash}, 32'd0);
        chk("jmp_fl_t2", {31'd0, flushing}, 32'd0);
        tick();
        chk("jmp_flushcnt", flush_count, save_fcnt + 32'd1);
        chk("jmp_bubbles", bubble_count, save_bub);

        // Second jump inside the flush window extends it
        save_fcnt = flush_count;
        step(0, 0, 0, 1'b1, 1'b0);
        drive(0, 0, 0, 1'b1, 1'b0);
        chk("jj_sq_t1", {31'd0, squash}, 32'd1);
        tick();
        drive(0, 0, 0, 1'b0, 1'b0);
        chk("jj_sq_t2", {31'd0, squash}, 32'd1);
        chk("jj_fl_t2", {31'd0, flushing}, 32'd1);
        tick();
        drive(0, 0, 0, 1'b0, 1'b0);
        chk("jj_sq_t3", {31'd0, squash}, 32'd0);
        tick();
        chk("jj_flushcnt", flush_count, save_fcnt + 32'd2);

        // Memory freeze during a hazard
        save_bub = bubble_count;
        step(0, 0, 5, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(5, 0, 0, 1'b0, 1'b1);
            check_model();
            chk("frz_stall", {31'd0, stall}, 32'd1);
            chk("frz_fh", {31'd0, fetch_hold}, 32'd1);
            chk("frz_bubbles", bubble_count, save_bub);
            tick();
        end
        step(5, 0, 0, 1'b0, 1'b0);
        step(5, 0, 0, 1'b0, 1'b0);
        drive(5, 0, 0, 1'b0, 1'b0);
        chk("frz_done_sq", {31'd0, squash}, 32'd0);
        chk("frz_total", bubble_count, save_bub + 32'd2);
        tick();

        // Asynchronous reset in the middle of a flush
        step(0, 0, 5, 1'b1, 1'b0);
        drive(0, 0, 0, 1'b0, 1'b0);
        chk("ar_pre_fl", {31'd0, flushing}, 32'd1);
        rst = 1'b0;
        #1;
        m_reset();
        chk("ar_flushing", {31'd0, flushing}, 32'd0);
        chk("ar_squash", {31'd0, squash}, 32'd0);
        chk("ar_bubble", bubble_count, 32'd0);
        chk("ar_flushcnt", flush_count, 32'd0);
        #1;
        rst = 1'b1;
        @(negedge clk);
        drive(5, 0, 0, 1'b0, 1'b0);
        chk("ar_post_sq", {31'd0, squash}, 32'd0);
        check_model();
        tick();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            s0   = int'($urandom_range(0, 7));
            s1   = int'($urandom_range(0, 7));
            jmp  = ($urandom_range(0, 7) == 0);
            busy = ($urandom_range(0, 5) == 0);
            d    = m_squash(s0, s1, jmp) ? 0 : int'($urandom_range(0, 7));
            step(s0, s1, d, jmp, busy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
